// File: rtl/avl_pkg.sv
// Shared types and constants for the two-master Avalon-MM arbiter.
// Grant states, the last-grant encoding and the full-word byte-enable mask.
package avl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

    // Encoding of the last_gnt register.
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/avl_rr_pick.sv
// Combinational two-way round-robin winner selection.
// On a tie the port that was not granted last wins.
module avl_rr_pick
    import avl_pkg::*;
(
    input  logic       req_instr,
    input  logic       req_data,
    input  logic       last_gnt,
    output arb_state_t gnt_state
);

    always_comb begin
        gnt_state = IDLE;
        if (req_instr && req_data) begin
            gnt_state = (last_gnt == LAST_D) ? GNT_I : GNT_D;
        end else if (req_instr) begin
            gnt_state = GNT_I;
        end else if (req_data) begin
            gnt_state = GNT_D;
        end
    end

endmodule

// File: rtl/avl_arbiter_2to1.sv
// Two-master (instr read-only, data read/write) to one-slave Avalon-MM arbiter with
// round-robin grant, back-to-back hand-over, completion counters and a stall watchdog.
module avl_arbiter_2to1
    import avl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned COUNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        i_address,
    input  logic               i_read,
    output logic [31:0]        i_readdata,
    output logic               i_waitrequest,
    input  logic [31:0]        d_address,
    input  logic [3:0]         d_byteenable,
    input  logic [31:0]        d_writedata,
    input  logic               d_read,
    input  logic               d_write,
    output logic [31:0]        d_readdata,
    output logic               d_waitrequest,
    output logic [31:0]        m_address,
    output logic [3:0]         m_byteenable,
    output logic [31:0]        m_writedata,
    output logic               m_read,
    output logic               m_write,
    input  logic [31:0]        m_readdata,
    input  logic               m_waitrequest,
    output logic [COUNT_W-1:0] i_count,
    output logic [COUNT_W-1:0] d_count,
    output logic               timeout_err
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYCLES);

    arb_state_t         state_q, state_d, pick_state;
    logic               last_gnt_q, last_gnt_d;
    logic [COUNT_W-1:0] i_count_q, i_count_d;
    logic [COUNT_W-1:0] d_count_q, d_count_d;
    logic [WdW-1:0]     wd_q, wd_d;
    logic               timeout_q, timeout_d;
    logic               req_instr, req_data, own_req, oth_req;

    assign req_instr = i_read;
    assign req_data  = d_read | d_write;

    avl_rr_pick u_rr_pick (
        .req_instr (req_instr),
        .req_data  (req_data),
        .last_gnt  (last_gnt_q),
        .gnt_state (pick_state)
    );

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        i_count_d  = i_count_q;
        d_count_d  = d_count_q;
        wd_d       = wd_q;
        timeout_d  = timeout_q;
        own_req    = (state_q == GNT_I) ? req_instr : req_data;
        oth_req    = (state_q == GNT_I) ? req_data : req_instr;
        unique case (state_q)
            IDLE: begin
                state_d = pick_state;
                wd_d    = '0;
            end
            GNT_I, GNT_D: begin
                if (own_req && !m_waitrequest) begin
                    if (state_q == GNT_I) begin
                        i_count_d  = i_count_q + COUNT_W'(1);
                        last_gnt_d = LAST_I;
                    end else begin
                        d_count_d  = d_count_q + COUNT_W'(1);
                        last_gnt_d = LAST_D;
                    end
                    wd_d = '0;
                    if (oth_req) begin
                        state_d = (state_q == GNT_I) ? GNT_D : GNT_I;
                    end
                end else if (!own_req) begin
                    state_d = IDLE;
                    wd_d    = '0;
                end else begin
                    // Stalled: saturate the watchdog; the grant is held regardless.
                    if (wd_q != WdMax) begin
                        wd_d = wd_q + WdW'(1);
                    end
                    if (wd_d == WdMax) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_address     = '0;
        m_byteenable  = '0;
        m_writedata   = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        i_readdata    = '0;
        d_readdata    = '0;
        unique case (state_q)
            GNT_I: begin
                m_address     = i_address;
                m_byteenable  = BE_WORD;
                m_read        = i_read;
                i_waitrequest = m_waitrequest;
                i_readdata    = m_readdata;
            end
            GNT_D: begin
                m_address     = d_address;
                m_byteenable  = d_byteenable;
                m_writedata   = d_writedata;
                m_read        = d_read;
                m_write       = d_write;
                d_waitrequest = m_waitrequest;
                d_readdata    = m_readdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_gnt_q <= LAST_D;
            i_count_q  <= '0;
            d_count_q  <= '0;
            wd_q       <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            i_count_q  <= i_count_d;
            d_count_q  <= d_count_d;
            wd_q       <= wd_d;
            timeout_q  <= timeout_d;
        end
    end

    assign i_count     = i_count_q;
    assign d_count     = d_count_q;
    assign timeout_err = timeout_q;

    // Illegal master behaviour is a harness bug; stop the simulation on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(d_read && d_write))
                else $fatal(1, "d_read and d_write asserted together");
            if (state_q == GNT_I && i_read) begin
                assert (i_address[1:0] == 2'b00) else $fatal(1, "unaligned instr address");
            end
            if (state_q == GNT_D && req_data) begin
                assert (d_address[1:0] == 2'b00) else $fatal(1, "unaligned data address");
            end
        end
    end

endmodule

// File: tb/tb_avl_arbiter_2to1.sv
// Randomized self-checking bench for avl_arbiter_2to1 with a transaction-level
// arbitration model and a reference copy of the slave memory.
module tb_avl_arbiter_2to1;

    localparam int T = 8;

    logic        clk, rst;
    logic [31:0] i_address, i_readdata;
    logic        i_read, i_waitrequest;
    logic [31:0] d_address, d_writedata, d_readdata;
    logic [3:0]  d_byteenable;
    logic        d_read, d_write, d_waitrequest;
    logic [31:0] m_address, m_writedata, m_readdata;
    logic [3:0]  m_byteenable;
    logic        m_read, m_write, m_waitrequest;
    logic [31:0] i_count, d_count;
    logic        timeout_err;

    avl_arbiter_2to1 #(.TIMEOUT_CYCLES(T), .COUNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_address     (i_address),
        .i_read        (i_read),
        .i_readdata    (i_readdata),
        .i_waitrequest (i_waitrequest),
        .d_address     (d_address),
        .d_byteenable  (d_byteenable),
        .d_writedata   (d_writedata),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_readdata    (d_readdata),
        .d_waitrequest (d_waitrequest),
        .m_address     (m_address),
        .m_byteenable  (m_byteenable),
        .m_writedata   (m_writedata),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .i_count       (i_count),
        .d_count       (d_count),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: 64-word memory, combinational read, byte-lane writes.
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        swait, mem_ready;

    function automatic logic [31:0] seed_word(int k);
        return (k * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign m_readdata    = mem[m_address[7:2]];
    assign m_waitrequest = swait;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 64; k++) mem[k] <= seed_word(k);
        end else if (m_write && !m_waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (m_byteenable[b]) mem[m_address[7:2]][b*8 +: 8] <= m_writedata[b*8 +: 8];
        end
    end

    int checks, errors;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Model: owner 0=none 1=instr 2=data; last is the port served last.
    int          owner, last, stall;
    logic [31:0] mi_cnt, md_cnt;
    bit          merr, ci, cd;
    logic [31:0] obs_drd;

    task automatic model_reset();
        owner = 0; last = 2; stall = 0;
        mi_cnt = 0; md_cnt = 0; merr = 0; ci = 0; cd = 0;
    endtask

    task automatic step();
        logic [31:0] e_ma, e_wd, e_ird, e_drd;
        logic [3:0]  e_be;
        logic        e_mr, e_mw, e_iw, e_dw;
        bit          ri, rd, own, oth;
        int          nxt;
        @(negedge clk);
        e_ma = 0; e_wd = 0; e_be = 0; e_mr = 0; e_mw = 0;
        e_iw = 1; e_dw = 1; e_ird = 0; e_drd = 0;
        if (owner == 1) begin
            e_ma = i_address; e_be = 4'hF; e_mr = i_read;
            e_iw = swait; e_ird = ref_mem[i_address[7:2]];
        end else if (owner == 2) begin
            e_ma = d_address; e_be = d_byteenable; e_wd = d_writedata;
            e_mr = d_read; e_mw = d_write; e_dw = swait; e_drd = ref_mem[d_address[7:2]];
        end
        check("m_read", m_read, e_mr);
        check("m_write", m_write, e_mw);
        check("m_address", m_address, e_ma);
        check("m_byteenable", m_byteenable, e_be);
        check("m_writedata", m_writedata, e_wd);
        check("i_waitrequest", i_waitrequest, e_iw);
        check("d_waitrequest", d_waitrequest, e_dw);
        check("i_readdata", i_readdata, e_ird);
        check("d_readdata", d_readdata, e_drd);
        check("i_count", i_count, mi_cnt);
        check("d_count", d_count, md_cnt);
        check("timeout_err", timeout_err, merr);
        obs_drd = d_readdata;

        ri = i_read; rd = d_read | d_write;
        ci = (owner == 1) && ri && !swait;
        cd = (owner == 2) && rd && !swait;
        if (cd && d_write)
            for (int b = 0; b < 4; b++)
                if (d_byteenable[b]) ref_mem[d_address[7:2]][b*8 +: 8] = d_writedata[b*8 +: 8];
        if (owner == 0) begin
            if (ri && rd) nxt = (last == 2) ? 1 : 2;
            else if (ri) nxt = 1;
            else if (rd) nxt = 2;
            else nxt = 0;
        end else begin
            own = (owner == 1) ? ri : rd;
            oth = (owner == 1) ? rd : ri;
            if (own && !swait) begin
                if (owner == 1) mi_cnt++; else md_cnt++;
                last = owner; stall = 0;
                nxt = oth ? 3 - owner : owner;
            end else if (!own) begin
                nxt = 0; stall = 0;
            end else begin
                nxt = owner;
                if (stall < T) stall++;
                if (stall == T) merr = 1;
            end
        end
        owner = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_read = 0; d_read = 0; d_write = 0; swait = 0;
        i_address = 0; d_address = 0; d_byteenable = 0; d_writedata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit done;
        int op;
        checks = 0; errors = 0;
        mem_ready = 0;
        idle_inputs();
        rst = 0;
        for (int k = 0; k < 64; k++) ref_mem[k] = seed_word(k);
        repeat (2) @(posedge clk);
        mem_ready = 1;
        do_reset();

        // Reset state
        check("rst_i_count", i_count, 0);
        check("rst_d_count", d_count, 0);
        check("rst_timeout", timeout_err, 0);
        step();

        // Instruction-only read
        i_address = 32'hBFC0_0000; i_read = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (ci) i_read = 0;
        end
        check("instr_only_count", i_count, 1);

        // Tie from reset: instr first, then data
        do_reset();
        i_address = 32'h0000_0010; i_read = 1;
        d_address = 32'h0000_0020; d_read = 1; d_byteenable = 4'hF;
        step(); step();
        if (ci) i_read = 0;
        check("tie_i_first", i_count, 1);
        check("tie_d_wait", d_count, 0);
        step();
        if (cd) d_read = 0;
        check("tie_d_next", d_count, 1);
        step();

        // Sustained alternation with a zero-wait slave
        do_reset();
        i_address = 32'h0000_0040; i_read = 1;
        d_address = 32'h0000_0044; d_read = 1; d_byteenable = 4'hF;
        repeat (7) step();
        check("sustain_i", i_count, 3);
        check("sustain_d", d_count, 3);
        i_read = 0; d_read = 0;
        step();

        // Partial byte write then readback
        d_address = 32'h4; d_byteenable = 4'b0010; d_writedata = 32'hAABB_CCDD; d_write = 1;
        done = 0;
        for (int k = 0; k < 4 && !done; k++) begin
            step();
            if (cd) begin d_write = 0; done = 1; end
        end
        check("bw_write_done", done, 1);
        d_byteenable = 4'hF; d_read = 1;
        done = 0;
        for (int k = 0; k < 4 && !done; k++) begin
            step();
            if (cd) begin d_read = 0; done = 1; end
        end
        check("bw_read_done", done, 1);
        check("bw_byte1", obs_drd[15:8], 8'hCC);
        step();

        // Asynchronous reset in the middle of a stalled data transfer
        d_address = 32'h8; d_read = 1; swait = 1;
        step(); step();
        check("mid_owner_d", d_waitrequest, 1);
        rst = 0;
        #1;
        check("arst_m_read", m_read, 0);
        check("arst_m_write", m_write, 0);
        check("arst_i_wait", i_waitrequest, 1);
        check("arst_d_wait", d_waitrequest, 1);
        check("arst_i_count", i_count, 0);
        check("arst_d_count", d_count, 0);
        check("arst_timeout", timeout_err, 0);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            step();
            if (i_read && !ci) begin
                if ($urandom_range(0, 19) == 0) i_read = 0;
            end else begin
                i_read = ($urandom_range(0, 2) != 0);
                i_address = $urandom() & 32'hFFFF_FFFC;
            end
            if ((d_read || d_write) && !cd) begin
                if ($urandom_range(0, 19) == 0) begin d_read = 0; d_write = 0; end
            end else begin
                op = $urandom_range(0, 2);
                d_read = (op == 1); d_write = (op == 2);
                d_address = $urandom() & 32'hFFFF_FFFC;
                d_byteenable = 4'($urandom_range(1, 15));
                d_writedata = $urandom();
            end
            swait = ($urandom_range(0, 3) == 0);
        end

        // Watchdog: stall an instr read past the timeout
        do_reset();
        i_address = 32'h0000_000C; i_read = 1; swait = 1;
        repeat (1 + T - 1) step();
        check("wd_before", timeout_err, 0);
        step();
        check("wd_set", timeout_err, 1);
        repeat (5) step();
        check("wd_sticky", timeout_err, 1);
        check("wd_no_count", i_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
